// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite slave front-end of the UART register bank.
// Optional feature macro used by this slice: AXI_RR_ARB_EN (round-robin
// read/write arbitration; fixed write priority when undefined).
package axi4lite_pkg;

  // AXI response codes this slave can produce (never DECERR/EXOKAY).
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Controller sequencing states; one transaction in flight at a time.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_COLLECT = 3'd1,
    WR_EXEC    = 3'd2,
    WR_RESP    = 3'd3,
    RD_CAP     = 3'd4,
    RD_RESP    = 3'd5
  } ctrl_state_t;

  // Map an address range check onto the response code returned to the master.
  function automatic resp_t resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4lite_rw_arbiter.sv
// Read/write grant logic for the AXI4-Lite slave controller.
// Macro AXI_RR_ARB_EN: when defined, a simultaneous read and write request
// is resolved round-robin (write wins the first tie after reset); when
// undefined, writes have fixed priority and the block is purely combinational.
module axi4lite_rw_arbiter (
`ifdef AXI_RR_ARB_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic grant_en,
  input  logic wr_req,
  input  logic rd_req,
  output logic grant_wr,
  output logic grant_rd
);

`ifdef AXI_RR_ARB_EN
  // 1 means the last grant went to the read side, so a write wins the next tie.
  logic last_rd_r;

  // Grant selection: alternate sides on a tie, otherwise serve the requester.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (grant_en) begin
      if (wr_req && rd_req) begin
        if (last_rd_r) begin
          grant_wr = 1'b1;
        end else begin
          grant_rd = 1'b1;
        end
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end else begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
      end
    end else begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
    end
  end

  // Round-robin pointer: remembers which side received the most recent grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_rd_r <= 1'b1;
    end else if (grant_wr) begin
      last_rd_r <= 1'b0;
    end else if (grant_rd) begin
      last_rd_r <= 1'b1;
    end else begin
      last_rd_r <= last_rd_r;
    end
  end
`else
  // Fixed write priority: a read is granted only when no write is requesting.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (grant_en) begin
      if (wr_req) begin
        grant_wr = 1'b1;
      end else if (rd_req) begin
        grant_rd = 1'b1;
      end else begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
      end
    end else begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/axi4lite_slave_ctrl.sv
// AXI4-Lite slave front-end for the UART register bank: terminates AW/W/B
// and AR/R, arbitrates reads against writes, issues a single-cycle write
// strobe and a registered read capture on the bank's flat port.
// Macro AXI_RR_ARB_EN selects round-robin arbitration (see axi4lite_rw_arbiter).
module axi4lite_slave_ctrl
  import axi4lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic                bank_wr_amba,
  output logic [ADDR_W-1:0]   bank_addr_wc,
  output logic [DATA_W/8-1:0] bank_strb,
  output logic [DATA_W-1:0]   bank_data_in,
  output logic [ADDR_W-1:0]   bank_addr_rc,
  input  logic [DATA_W-1:0]   bank_data_out
);

  localparam int STRB_W = DATA_W / 8;
  // Word count in the width of a word address, for the out-of-range compare.
  localparam logic [ADDR_W-3:0] NUM_WORDS = (ADDR_W-2)'(NUM_REGS);

  ctrl_state_t state_r;
  ctrl_state_t state_next_s;

  logic [ADDR_W-1:0] awaddr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [STRB_W-1:0] wstrb_r;
  logic [ADDR_W-1:0] araddr_r;
  logic              aw_done_r;
  logic              w_done_r;
  logic              bank_wr_r;
  resp_t             bresp_r;
  logic              bvalid_r;
  logic [DATA_W-1:0] rdata_r;
  resp_t             rresp_r;
  logic              rvalid_r;

  logic awready_s;
  logic wready_s;
  logic arready_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic ar_hs_s;
  logic grant_wr_s;
  logic grant_rd_s;
  logic wr_req_s;
  logic rd_req_s;

  // Values the write will execute with: this cycle's beat if it handshakes now.
  logic [ADDR_W-3:0] eff_aw_word_s;
  logic [STRB_W-1:0] eff_wstrb_s;
  logic              wr_in_range_s;
  logic              rd_in_range_s;

  assign wr_req_s = s_awvalid | s_wvalid;
  assign rd_req_s = s_arvalid;

  axi4lite_rw_arbiter u_arb (
`ifdef AXI_RR_ARB_EN
    .clk      (clk),
    .rst      (rst),
`endif
    .grant_en (state_r == IDLE),
    .wr_req   (wr_req_s),
    .rd_req   (rd_req_s),
    .grant_wr (grant_wr_s),
    .grant_rd (grant_rd_s)
  );

  // Readies are forced low while reset is asserted.
  assign s_awready = awready_s & rst;
  assign s_wready  = wready_s & rst;
  assign s_arready = arready_s & rst;

  assign aw_hs_s = s_awvalid & s_awready;
  assign w_hs_s  = s_wvalid & s_wready;
  assign ar_hs_s = s_arvalid & s_arready;

  assign eff_aw_word_s = aw_hs_s ? s_awaddr[ADDR_W-1:2] : awaddr_r[ADDR_W-1:2];
  assign eff_wstrb_s   = w_hs_s ? s_wstrb : wstrb_r;
  assign wr_in_range_s = (eff_aw_word_s < NUM_WORDS);
  assign rd_in_range_s = (araddr_r[ADDR_W-1:2] < NUM_WORDS);

  // Next-state and channel-ready decode for the transaction sequencer.
  always_comb begin
    state_next_s = state_r;
    awready_s    = 1'b0;
    wready_s     = 1'b0;
    arready_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_wr_s) begin
          awready_s = 1'b1;
          wready_s  = 1'b1;
          if (aw_hs_s && w_hs_s) begin
            state_next_s = WR_EXEC;
          end else if (aw_hs_s || w_hs_s) begin
            state_next_s = WR_COLLECT;
          end else begin
            state_next_s = IDLE;
          end
        end else if (grant_rd_s) begin
          arready_s = 1'b1;
          if (ar_hs_s) begin
            state_next_s = RD_CAP;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_COLLECT: begin
        awready_s = ~aw_done_r;
        wready_s  = ~w_done_r;
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_next_s = WR_EXEC;
        end else begin
          state_next_s = WR_COLLECT;
        end
      end
      WR_EXEC: begin
        state_next_s = WR_RESP;
      end
      WR_RESP: begin
        if (s_bready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WR_RESP;
        end
      end
      RD_CAP: begin
        state_next_s = RD_RESP;
      end
      RD_RESP: begin
        if (s_rready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RD_RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register, channel latches and registered AXI/bank outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      awaddr_r  <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      araddr_r  <= {ADDR_W{1'b0}};
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      bank_wr_r <= 1'b0;
      bresp_r   <= RESP_OKAY;
      bvalid_r  <= 1'b0;
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;

      // AW and W are captured independently; flags clear once the write executes.
      if (state_r == WR_EXEC) begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end else begin
        if (aw_hs_s) begin
          awaddr_r  <= s_awaddr;
          aw_done_r <= 1'b1;
        end
        if (w_hs_s) begin
          wdata_r  <= s_wdata;
          wstrb_r  <= s_wstrb;
          w_done_r <= 1'b1;
        end
      end

      // An all-zero strobe would be taken by the bank as a full-word write, so suppress it.
      bank_wr_r <= (state_next_s == WR_EXEC) && wr_in_range_s &&
                   (eff_wstrb_s != {STRB_W{1'b0}});
      if (state_next_s == WR_EXEC) begin
        bresp_r <= resp_for(wr_in_range_s);
      end
      bvalid_r <= (state_next_s == WR_RESP);

      if (ar_hs_s) begin
        araddr_r <= s_araddr;
      end
      if (state_r == RD_CAP) begin
        rdata_r <= rd_in_range_s ? bank_data_out : {DATA_W{1'b0}};
        rresp_r <= resp_for(rd_in_range_s);
      end
      rvalid_r <= (state_next_s == RD_RESP);
    end
  end

  assign s_bresp      = bresp_r;
  assign s_bvalid     = bvalid_r;
  assign s_rdata      = rdata_r;
  assign s_rresp      = rresp_r;
  assign s_rvalid     = rvalid_r;
  assign bank_wr_amba = bank_wr_r;
  assign bank_addr_wc = awaddr_r;
  assign bank_strb    = wstrb_r;
  assign bank_data_in = wdata_r;
  assign bank_addr_rc = araddr_r;

endmodule

// File: tb/tb_axi4lite_slave_ctrl.sv
// Self-checking bench for axi4lite_slave_ctrl: a table of single write/read
// transactions plus hand-written multi-cycle sequences (split AW/W, read
// data hold, arbitration ties, reset during a pending response).
// Expected arbitration order follows AXI_RR_ARB_EN.
module tb_axi4lite_slave_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        bank_wr_amba;
  logic [31:0] bank_addr_wc;
  logic [3:0]  bank_strb;
  logic [31:0] bank_data_in;
  logic [31:0] bank_addr_rc;
  logic [31:0] bank_data_out;

  int checks = 0;
  int failures = 0;

  axi4lite_slave_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(2)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bank_wr_amba(bank_wr_amba), .bank_addr_wc(bank_addr_wc), .bank_strb(bank_strb),
    .bank_data_in(bank_data_in), .bank_addr_rc(bank_addr_rc), .bank_data_out(bank_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;      // write data, or bank_data_out for a read
    logic [3:0]  strb;
    logic        exp_stb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((which == 0 && s_bvalid) || (which == 1 && s_rvalid) ||
          (which == 2 && s_arready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic exp_stb,
                          input logic [1:0] exp_resp);
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    chk("wr_awready", s_awready, 1'b1);
    chk("wr_wready", s_wready, 1'b1);
    chk("wr_arready_low", s_arready, 1'b0);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    chk("wr_strobe", bank_wr_amba, exp_stb);
    chk("wr_bvalid_early", s_bvalid, 1'b0);
    chk("wr_awready_exec", s_awready, 1'b0);
    if (exp_stb) begin
      chk("wr_addr_wc", bank_addr_wc, addr);
      chk("wr_data_in", bank_data_in, data);
      chk("wr_bank_strb", bank_strb, strb);
    end
    @(negedge clk);
    chk("wr_bvalid", s_bvalid, 1'b1);
    chk("wr_bresp", s_bresp, exp_resp);
    chk("wr_strobe_one_cycle", bank_wr_amba, 1'b0);
    chk("wr_rvalid_low", s_rvalid, 1'b0);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    @(negedge clk);
    chk("wr_bvalid_drop", s_bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] bank_val,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_resp);
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1'b1; bank_data_out = bank_val;
    @(negedge clk);
    chk("rd_arready", s_arready, 1'b1);
    chk("rd_awready_low", s_awready, 1'b0);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_early", s_rvalid, 1'b0);
    chk("rd_addr_rc", bank_addr_rc, addr);
    @(negedge clk);
    chk("rd_rvalid", s_rvalid, 1'b1);
    chk("rd_rdata", s_rdata, exp_rdata);
    chk("rd_rresp", s_rresp, exp_resp);
    chk("rd_bvalid_low", s_bvalid, 1'b0);
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    bank_data_out = 32'h0;
    @(negedge clk);
    chk("rd_rvalid_drop", s_rvalid, 1'b0);
  endtask

  initial begin
    bit ok;
    logic [2:0] exp_order;
    logic [2:0] got_order;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'hA5A5_1234, 4'hF, 1'b1, 2'b00, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_00FF, 4'h1, 1'b1, 2'b00, 32'h0};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'h0000_DEAD, 4'hF, 1'b0, 2'b10, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_1111, 4'h0, 1'b0, 2'b00, 32'h0};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h1234_5678, 4'h3, 1'b1, 2'b00, 32'h0};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_1234, 4'h0, 1'b0, 2'b00, 32'h0000_1234};
    vecs[6] = '{1'b0, 32'h0000_0008, 32'h0000_9999, 4'h0, 1'b0, 2'b10, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0005, 32'h0000_0077, 4'h0, 1'b0, 2'b00, 32'h0000_0077};
    vecs[8] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_0BAD, 4'hF, 1'b0, 2'b10, 32'h0};
    vecs[9] = '{1'b0, 32'h0000_0004, 32'h0000_CAFE, 4'h0, 1'b0, 2'b00, 32'h0000_CAFE};

    rst = 1'b0;
    s_awaddr = 32'h0; s_awvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0;
    s_wvalid = 1'b0; s_bready = 1'b0; s_araddr = 32'h0; s_arvalid = 1'b0;
    s_rready = 1'b0; bank_data_out = 32'h0;

    // Reset state, with write and read requests pending to prove readies stay low.
    repeat (2) @(posedge clk);
    #1; s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", s_awready, 1'b0);
    chk("rst_wready", s_wready, 1'b0);
    chk("rst_arready", s_arready, 1'b0);
    chk("rst_bvalid", s_bvalid, 1'b0);
    chk("rst_rvalid", s_rvalid, 1'b0);
    chk("rst_bresp", s_bresp, 2'b00);
    chk("rst_rresp", s_rresp, 2'b00);
    chk("rst_strobe", bank_wr_amba, 1'b0);
    chk("rst_addr_wc", bank_addr_wc, 32'h0);
    chk("rst_data_in", bank_data_in, 32'h0);
    chk("rst_addr_rc", bank_addr_rc, 32'h0);
    chk("rst_rdata", s_rdata, 32'h0);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_awready_noreq", s_awready, 1'b0);

    // Table of single transactions.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_stb, vecs[i].exp_resp);
      else
        do_read(vecs[i].addr, vecs[i].data, vecs[i].exp_rdata, vecs[i].exp_resp);
    end

    // W first, AW four cycles later.
    @(posedge clk); #1;
    s_wdata = 32'h0C0F_FEE0; s_wstrb = 4'hC; s_wvalid = 1'b1;
    @(negedge clk);
    chk("split_wready_first", s_wready, 1'b1);
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("split_wready_low", s_wready, 1'b0);
      chk("split_awready_high", s_awready, 1'b1);
      chk("split_no_strobe", bank_wr_amba, 1'b0);
      @(posedge clk); #1;
    end
    s_awaddr = 32'h0000_0004; s_awvalid = 1'b1;
    @(negedge clk);
    chk("split_awready", s_awready, 1'b1);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("split_strobe", bank_wr_amba, 1'b1);
    chk("split_addr_wc", bank_addr_wc, 32'h0000_0004);
    chk("split_data_in", bank_data_in, 32'h0C0F_FEE0);
    chk("split_strb", bank_strb, 4'hC);
    @(negedge clk);
    chk("split_bvalid", s_bvalid, 1'b1);
    chk("split_bresp", s_bresp, 2'b00);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;

    // Read data captured at RD_CAP holds while the bank value moves.
    @(posedge clk); #1;
    s_araddr = 32'h0000_0004; s_arvalid = 1'b1; bank_data_out = 32'h0000_0055;
    @(negedge clk);
    chk("hold_arready", s_arready, 1'b1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    @(negedge clk);
    chk("hold_rvalid_early", s_rvalid, 1'b0);
    @(posedge clk); #1;
    bank_data_out = 32'h0000_0066;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_rvalid", s_rvalid, 1'b1);
      chk("hold_rdata", s_rdata, 32'h0000_0055);
      @(posedge clk); #1;
    end
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    @(negedge clk);
    chk("hold_rvalid_drop", s_rvalid, 1'b0);

    // Three write/read ties; loser keeps its valid asserted throughout.
`ifdef AXI_RR_ARB_EN
    exp_order = 3'b101;
`else
    exp_order = 3'b111;
`endif
    got_order = 3'b000;
    @(posedge clk); #1;
    s_awaddr = 32'h0; s_wdata = 32'h0000_0001; s_wstrb = 4'hF;
    s_araddr = 32'h0; bank_data_out = 32'h0000_00AA;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("tie_exclusive", {31'd0, s_awready & s_arready}, 32'd0);
      got_order[2-r] = s_awready;
      @(posedge clk); #1;
      if (got_order[2-r]) begin
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        wait_sig(0, ok);
        chk("tie_bvalid_timeout", {31'd0, ok}, 32'd1);
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
      end else begin
        s_arvalid = 1'b0;
        wait_sig(1, ok);
        chk("tie_rvalid_timeout", {31'd0, ok}, 32'd1);
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        s_arvalid = 1'b1;
      end
    end
    chk("tie_order", {29'd0, got_order}, {29'd0, exp_order});
    // Drain the remaining requests: write valids drop, pending read completes.
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_sig(2, ok);
    chk("drain_arready_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    wait_sig(1, ok);
    chk("drain_rvalid_timeout", {31'd0, ok}, 32'd1);
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;

    // Reset while a write response is pending.
    @(posedge clk); #1;
    s_awaddr = 32'h0000_0004; s_wdata = 32'h0000_BEEF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_sig(0, ok);
    chk("rstmid_bvalid_timeout", {31'd0, ok}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid_bvalid", s_bvalid, 1'b0);
      chk("rstmid_strobe", bank_wr_amba, 1'b0);
      chk("rstmid_addr_wc", bank_addr_wc, 32'h0);
    end
    do_write(32'h0000_0000, 32'h0000_7777, 4'hF, 1'b1, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
